// File: rtl/axi_s0_wr_arbiter.sv
// Round-robin arbiter sharing the Slave 0 AXI write channels among NM masters.
// A single AW grant is held through every W beat and the B handshake; out-of-range writes are answered locally with DECERR.
module axi_s0_wr_arbiter #(
  parameter int NM  = 4,
  parameter int IDW = 6,
  parameter int DW  = 32,
  parameter int ADW = 32,
  parameter logic [ADW-1:0] BASE_ADDR = 'h0000_0000,
  parameter logic [ADW-1:0] END_ADDR  = 'h0000_0FFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NM-1:0]       m_awvalid,
  output logic [NM-1:0]       m_awready,
  input  logic [NM*IDW-1:0]   m_awid,
  input  logic [NM*ADW-1:0]   m_awaddr,
  input  logic [NM*8-1:0]     m_awlen,
  input  logic [NM-1:0]       m_wvalid,
  input  logic [NM-1:0]       m_wlast,
  input  logic [NM*DW-1:0]    m_wdata,
  input  logic [NM*DW/8-1:0]  m_wstrb,
  output logic [NM-1:0]       m_wready,
  output logic [NM-1:0]       m_bvalid,
  input  logic [NM-1:0]       m_bready,
  output logic [IDW-1:0]      m_bid,
  output logic [1:0]          m_bresp,
  output logic                s0_awvalid,
  input  logic                s0_awready,
  output logic [IDW-1:0]      s0_awid,
  output logic [ADW-1:0]      s0_awaddr,
  output logic [7:0]          s0_awlen,
  output logic                s0_wvalid,
  input  logic                s0_wready,
  output logic                s0_wlast,
  output logic [DW-1:0]       s0_wdata,
  output logic [DW/8-1:0]     s0_wstrb,
  input  logic                s0_bvalid,
  output logic                s0_bready,
  input  logic [IDW-1:0]      s0_bid,
  input  logic [1:0]          s0_bresp,
  output logic [NM-1:0]       grant,
  output logic                err_wlast
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, ERR_DATA, ERR_RESP} state_t;

  state_t         state_reg;
  logic [PW-1:0]  rr_ptr_reg;
  logic [PW-1:0]  gnt_idx_reg;
  logic [NM-1:0]  grant_reg;
  logic [IDW-1:0] awid_reg;
  logic [ADW-1:0] awaddr_reg;
  logic [7:0]     awlen_reg;
  logic [7:0]     beat_cnt_reg;
  logic           s0_awvalid_reg;
  logic           err_wlast_reg;

  logic [PW-1:0]  win_idx;
  logic [PW-1:0]  cand_idx;
  logic           win_found;
  logic [ADW-1:0] win_addr;
  logic [IDW-1:0] win_id;
  logic [7:0]     win_len;
  logic           win_in_range;
  logic           sel_wvalid;
  logic           sel_wlast;
  logic           sel_bready;
  logic           w_hs;
  logic           last_beat;
  logic [PW-1:0]  rr_next;

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    win_idx   = '0;
    cand_idx  = '0;
    win_found = 1'b0;
    for (int k = NM - 1; k >= 0; k--) begin
      cand_idx = PW'((int'(rr_ptr_reg) + k) % NM);
      if (m_awvalid[cand_idx]) begin
        win_idx   = cand_idx;
        win_found = 1'b1;
      end
    end
  end

  assign win_addr = m_awaddr[win_idx*ADW +: ADW];
  assign win_id   = m_awid[win_idx*IDW +: IDW];
  assign win_len  = m_awlen[win_idx*8 +: 8];
  // Offset compare keeps a single unsigned test even when BASE_ADDR is zero.
  assign win_in_range = (win_addr - BASE_ADDR) <= (END_ADDR - BASE_ADDR);

  assign sel_wvalid = m_wvalid[gnt_idx_reg];
  assign sel_wlast  = m_wlast[gnt_idx_reg];
  assign sel_bready = m_bready[gnt_idx_reg];
  assign last_beat  = (beat_cnt_reg == awlen_reg);
  assign w_hs       = sel_wvalid && ((state_reg == DATA && s0_wready) || state_reg == ERR_DATA);
  assign rr_next    = (gnt_idx_reg == PW'(NM - 1)) ? '0 : gnt_idx_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      gnt_idx_reg    <= '0;
      grant_reg      <= '0;
      awid_reg       <= '0;
      awaddr_reg     <= '0;
      awlen_reg      <= '0;
      beat_cnt_reg   <= '0;
      s0_awvalid_reg <= 1'b0;
      err_wlast_reg  <= 1'b0;
    end else begin
      err_wlast_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            grant_reg    <= NM'(1) << win_idx;
            gnt_idx_reg  <= win_idx;
            awid_reg     <= win_id;
            awaddr_reg   <= win_addr;
            awlen_reg    <= win_len;
            beat_cnt_reg <= '0;
            if (win_in_range) begin
              state_reg      <= ADDR;
              s0_awvalid_reg <= 1'b1;
            end else begin
              state_reg <= ERR_DATA;
            end
          end
        end
        ADDR: begin
          if (s0_awready) begin
            s0_awvalid_reg <= 1'b0;
            state_reg      <= DATA;
          end
        end
        DATA, ERR_DATA: begin
          if (w_hs) begin
            err_wlast_reg <= (sel_wlast != last_beat);
            if (last_beat) begin
              beat_cnt_reg <= '0;
              state_reg    <= (state_reg == DATA) ? RESP : ERR_RESP;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
          end
        end
        RESP: begin
          if (s0_bvalid && sel_bready) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= rr_next;
          end
        end
        ERR_RESP: begin
          if (sel_bready) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= rr_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NM; gi++) begin : g_master
    assign m_awready[gi] = !rst && (state_reg == IDLE) && win_found && (win_idx == PW'(gi));
    assign m_wready[gi]  = grant_reg[gi] &&
                           ((state_reg == DATA && s0_wready) || state_reg == ERR_DATA);
    assign m_bvalid[gi]  = grant_reg[gi] &&
                           ((state_reg == RESP && s0_bvalid) || state_reg == ERR_RESP);
  end

  assign s0_awvalid = s0_awvalid_reg;
  assign s0_awid    = awid_reg;
  assign s0_awaddr  = awaddr_reg;
  assign s0_awlen   = awlen_reg;
  assign s0_wvalid  = (state_reg == DATA) && sel_wvalid;
  assign s0_wlast   = (state_reg == DATA) && last_beat;
  assign s0_wdata   = (state_reg == DATA) ? m_wdata[gnt_idx_reg*DW +: DW] : '0;
  assign s0_wstrb   = (state_reg == DATA) ? m_wstrb[gnt_idx_reg*SW +: SW] : '0;
  assign s0_bready  = (state_reg == RESP) && sel_bready;

  assign m_bid   = (state_reg == RESP)     ? s0_bid   :
                   (state_reg == ERR_RESP) ? awid_reg : '0;
  assign m_bresp = (state_reg == RESP)     ? s0_bresp :
                   (state_reg == ERR_RESP) ? 2'b11    : 2'b00;

  assign grant     = grant_reg;
  assign err_wlast = err_wlast_reg;

endmodule

// File: tb/tb_axi_s0_wr_arbiter.sv
// Directed bench for axi_s0_wr_arbiter: reset, fairness, single write, decode error,
// backpressure, wlast mismatch and mid-burst reset, each with hand-computed expectations.
module tb_axi_s0_wr_arbiter;
  localparam int NM  = 4;
  localparam int IDW = 6;
  localparam int DW  = 32;
  localparam int ADW = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [NM-1:0]       m_awvalid, m_awready;
  logic [NM*IDW-1:0]   m_awid;
  logic [NM*ADW-1:0]   m_awaddr;
  logic [NM*8-1:0]     m_awlen;
  logic [NM-1:0]       m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [NM*DW-1:0]    m_wdata;
  logic [NM*DW/8-1:0]  m_wstrb;
  logic [IDW-1:0]      m_bid;
  logic [1:0]          m_bresp;
  logic                s0_awvalid, s0_awready;
  logic [IDW-1:0]      s0_awid;
  logic [ADW-1:0]      s0_awaddr;
  logic [7:0]          s0_awlen;
  logic                s0_wvalid, s0_wready, s0_wlast;
  logic [DW-1:0]       s0_wdata;
  logic [DW/8-1:0]     s0_wstrb;
  logic                s0_bvalid, s0_bready;
  logic [IDW-1:0]      s0_bid;
  logic [1:0]          s0_bresp;
  logic [NM-1:0]       grant;
  logic                err_wlast;

  int total = 0;
  int bad   = 0;

  axi_s0_wr_arbiter #(.NM(NM), .IDW(IDW), .DW(DW), .ADW(ADW)) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awid(s0_awid),
    .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wlast(s0_wlast),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bid(s0_bid), .s0_bresp(s0_bresp),
    .grant(grant), .err_wlast(err_wlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_aw(input int i, input logic [IDW-1:0] id, input logic [ADW-1:0] addr,
                        input logic [7:0] len);
    m_awvalid[i]             = 1'b1;
    m_awid[i*IDW +: IDW]     = id;
    m_awaddr[i*ADW +: ADW]   = addr;
    m_awlen[i*8 +: 8]        = len;
  endtask

  task automatic set_w(input int i, input logic v, input logic [DW-1:0] d, input logic last);
    m_wvalid[i]          = v;
    m_wdata[i*DW +: DW]  = d;
    m_wstrb[i*4 +: 4]    = 4'hF;
    m_wlast[i]           = last;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0;
    m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
    s0_awready = 1'b0; s0_wready = 1'b0; s0_bvalid = 1'b0; s0_bid = '0; s0_bresp = '0;
  endtask

  initial begin
    logic [NM-1:0] got;
    int c;
    int b;

    clear_inputs();
    rst = 1'b1;
    // Fairness stimulus is already present during reset: nothing may respond.
    for (int i = 0; i < NM; i++) begin
      set_aw(i, IDW'(i), ADW'(32'h10 * i), 8'd0);
      set_w(i, 1'b1, DW'(32'hF000_0000 + i), 1'b1);
    end
    m_bready = '1; s0_awready = 1'b1; s0_wready = 1'b1; s0_bvalid = 1'b1;
    tick(); tick();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_awready", 64'(m_awready), 64'h0);
    chk("rst_wready", 64'(m_wready), 64'h0);
    chk("rst_bvalid", 64'(m_bvalid), 64'h0);
    chk("rst_s0_valids", {61'h0, s0_awvalid, s0_wvalid, s0_bready}, 64'h0);
    chk("rst_err", 64'(err_wlast), 64'h0);
    rst = 1'b0;

    // Fairness: all masters request continuously with len=0.
    for (int t = 0; t < 5; t++) begin
      got = '0;
      c = 0;
      while (got == '0 && c < 20) begin
        #1;
        if (m_awready != '0) got = m_awready;
        else begin tick(); c++; end
      end
      chk("fair_grant", 64'(got), 64'(4'b0001 << (t % 4)));
      tick();
      if (t == 4) m_awvalid = '0;
      chk("fair_awid", 64'(s0_awid), 64'(t % 4));
      tick();
      #1;
      chk("fair_wlast_len0", {62'h0, s0_wvalid, s0_wlast}, 64'h3);
      $display("txn fair %0d grant=%b", t, got);
    end
    c = 0;
    while (grant != '0 && c < 10) begin tick(); c++; end
    chk("fair_done", 64'(grant), 64'h0);
    clear_inputs();

    // Single write: M1, addr 0x100, len 3, id 5.
    tick();
    set_aw(1, 6'd5, 32'h100, 8'd3);
    s0_awready = 1'b1; s0_wready = 1'b1;
    #1;
    chk("sw_awready", 64'(m_awready), 64'h2);
    chk("sw_awvalid_early", 64'(s0_awvalid), 64'h0);
    tick();
    m_awvalid = '0;
    chk("sw_awvalid", 64'(s0_awvalid), 64'h1);
    chk("sw_awaddr", 64'(s0_awaddr), 64'h100);
    chk("sw_awid_len", {50'h0, s0_awid, s0_awlen}, {50'h0, 6'd5, 8'd3});
    chk("sw_grant", 64'(grant), 64'h2);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_w(1, 1'b1, DW'(32'hA000_0000 + k), k == 3);
      #1;
      chk("sw_wvalid_wready", {59'h0, s0_wvalid, m_wready}, {59'h0, 1'b1, 4'h2});
      chk("sw_wdata", 64'(s0_wdata), 64'(32'hA000_0000 + k));
      chk("sw_wlast", 64'(s0_wlast), 64'(k == 3));
      tick();
      chk("sw_err", 64'(err_wlast), 64'h0);
    end
    set_w(1, 1'b0, '0, 1'b0);
    s0_bvalid = 1'b1; s0_bid = 6'd5; s0_bresp = 2'b00; m_bready[1] = 1'b1;
    #1;
    chk("sw_bvalid", 64'(m_bvalid), 64'h2);
    chk("sw_bid_bresp", {56'h0, m_bid, m_bresp}, {56'h0, 6'd5, 2'b00});
    chk("sw_bready", 64'(s0_bready), 64'h1);
    tick();
    chk("sw_end", {60'h0, m_bvalid | grant}, 64'h0);
    $display("txn single M1 id=5 len=3 done");
    clear_inputs();

    // Decode error: M2, addr 0x1000, len 1, id 3.
    tick();
    set_aw(2, 6'd3, 32'h1000, 8'd1);
    #1;
    chk("de_awready", 64'(m_awready), 64'h4);
    tick();
    m_awvalid = '0;
    chk("de_no_awvalid", 64'(s0_awvalid), 64'h0);
    chk("de_grant", 64'(grant), 64'h4);
    for (int k = 0; k < 2; k++) begin
      set_w(2, 1'b1, DW'(32'hD0 + k), k == 1);
      #1;
      chk("de_wready", 64'(m_wready), 64'h4);
      chk("de_no_s0_wvalid", 64'(s0_wvalid), 64'h0);
      tick();
    end
    set_w(2, 1'b0, '0, 1'b0);
    #1;
    chk("de_bvalid", 64'(m_bvalid), 64'h4);
    chk("de_bid_bresp", {56'h0, m_bid, m_bresp}, {56'h0, 6'd3, 2'b11});
    m_bready[2] = 1'b1;
    tick();
    chk("de_end", {60'h0, m_bvalid | grant}, 64'h0);
    $display("txn decerr M2 id=3 len=1 done");
    clear_inputs();

    // Backpressure: M3, addr 0x200, len 2, id 7.
    tick();
    set_aw(3, 6'd7, 32'h200, 8'd2);
    set_w(3, 1'b1, 32'hB000_0000, 1'b0);
    #1;
    chk("bp_awready", 64'(m_awready), 64'h8);
    tick();
    m_awvalid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_aw_hold", {31'h0, s0_awvalid, s0_awaddr}, {31'h0, 1'b1, 32'h200});
      chk("bp_w_stall", 64'(m_wready), 64'h0);
      tick();
    end
    s0_awready = 1'b1;
    #1;
    chk("bp_aw_hold_last", {50'h0, s0_awid, s0_awlen}, {50'h0, 6'd7, 8'd2});
    tick();
    s0_awready = 1'b0;
    b = 0;
    c = 0;
    while (b < 3 && c < 20) begin
      s0_wready = c[0];
      set_w(3, 1'b1, DW'(32'hB000_0000 + b), b == 2);
      #1;
      chk("bp_wready", 64'(m_wready), s0_wready ? 64'h8 : 64'h0);
      chk("bp_wlast", 64'(s0_wlast), 64'(b == 2));
      tick();
      if (s0_wready) b++;
      c++;
    end
    s0_wready = 1'b0;
    set_w(3, 1'b0, '0, 1'b0);
    s0_bvalid = 1'b1; s0_bid = 6'd7; s0_bresp = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_b_hold", {59'h0, s0_bready, m_bvalid}, {59'h0, 1'b0, 4'h8});
      tick();
    end
    m_bready[3] = 1'b1;
    #1;
    chk("bp_b_accept", {55'h0, s0_bready, m_bid, m_bresp}, {55'h0, 1'b1, 6'd7, 2'b00});
    tick();
    chk("bp_end", {60'h0, m_bvalid | grant}, 64'h0);
    $display("txn backpressure M3 id=7 len=2 done");
    clear_inputs();

    // wlast on the second of three beats, then reset in the middle of the burst.
    tick();
    set_aw(0, 6'd9, 32'h300, 8'd2);
    s0_awready = 1'b1; s0_wready = 1'b1;
    #1;
    chk("er_awready", 64'(m_awready), 64'h1);
    tick();
    m_awvalid = '0;
    tick();
    set_w(0, 1'b1, 32'hE0, 1'b0);
    tick();
    chk("er_no_err_beat0", 64'(err_wlast), 64'h0);
    set_w(0, 1'b1, 32'hE1, 1'b1);
    tick();
    chk("er_err_pulse", 64'(err_wlast), 64'h1);
    set_w(0, 1'b1, 32'hE2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("er_rst_grant", 64'(grant), 64'h0);
    chk("er_rst_err", 64'(err_wlast), 64'h0);
    chk("er_rst_w", {59'h0, s0_wvalid, m_wready}, 64'h0);
    set_aw(0, 6'd1, 32'h0, 8'd0);
    set_aw(1, 6'd2, 32'h0, 8'd0);
    #1;
    chk("er_rst_next_grant", 64'(m_awready), 64'h1);
    $display("txn wlast-error M0 id=9 len=2 cut by reset");
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
